// File: rtl/iccm_port_arbiter.sv
// ICCM single-port arbiter: shares one SRAM port between instruction fetch
// (read-only) and the UART programmer (read/write), with a RUN/DRAIN/PROG
// ownership FSM and a starvation guard that keeps fetch making progress.
//
// state | meaning
// RUN   | normal operation, programmer has priority, fetch starvation guard
// DRAIN | no grants, wait for in-flight read response to retire
// PROG  | programmer owns the port exclusively, fetch blocked
module iccm_port_arbiter #(
  parameter int AW       = 12,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          prog_mode_i,
  input  logic          prog_req_i,
  input  logic          prog_we_i,
  input  logic [AW-1:0] prog_addr_i,
  input  logic [DW-1:0] prog_wdata_i,
  input  logic [DW-1:0] prog_wmask_i,
  output logic          prog_gnt_o,
  output logic          prog_rvalid_o,
  output logic [DW-1:0] prog_rdata_o,
  input  logic          fetch_req_i,
  input  logic [AW-1:0] fetch_addr_i,
  output logic          fetch_gnt_o,
  output logic          fetch_rvalid_o,
  output logic [DW-1:0] fetch_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [DW-1:0] mem_wmask_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          prog_active_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    PROG  = 2'd2
  } state_e;

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  state_e     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       pend_vld_q, pend_vld_d;
  logic       pend_id_q, pend_id_d;
  logic       prog_active_q, prog_active_d;
  logic       fetch_gnt, prog_gnt;

  // Grant decision from current state and live requests; at most one wins.
  always_comb begin
    fetch_gnt = 1'b0;
    prog_gnt  = 1'b0;
    unique case (state_q)
      RUN: begin
        fetch_gnt = fetch_req_i & (~prog_req_i | (wait_cnt_q == MaxWait));
        prog_gnt  = prog_req_i & ~fetch_gnt;
      end
      PROG: begin
        prog_gnt = prog_req_i;
      end
      default: begin
        fetch_gnt = 1'b0;
        prog_gnt  = 1'b0;
      end
    endcase
  end

  // SRAM port mux; fetch never writes, idle port drives zeros.
  always_comb begin
    mem_req_o   = prog_gnt | fetch_gnt;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    if (fetch_gnt) begin
      mem_addr_o = fetch_addr_i;
    end else if (prog_gnt) begin
      mem_we_o    = prog_we_i;
      mem_addr_o  = prog_addr_i;
      mem_wdata_o = prog_wdata_i;
      mem_wmask_o = prog_wmask_i;
    end
  end

  // Next-state, starvation counter and read-response bookkeeping.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    pend_vld_d = mem_req_o & ~mem_we_o;
    pend_id_d  = prog_gnt;
    unique case (state_q)
      RUN: begin
        if (fetch_req_i && !fetch_gnt) begin
          wait_cnt_d = (wait_cnt_q == MaxWait) ? wait_cnt_q : wait_cnt_q + 4'd1;
        end
        if (prog_mode_i) state_d = DRAIN;
      end
      DRAIN: begin
        // Exiting programming mode takes precedence over finishing the drain.
        if (!prog_mode_i) begin
          state_d = RUN;
        end else if (!pend_vld_q || !pend_vld_d) begin
          state_d = PROG;
        end
      end
      PROG: begin
        if (!prog_mode_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    prog_active_d = (state_d == PROG);
  end

  // All state flops, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      pend_vld_q    <= 1'b0;
      pend_id_q     <= 1'b0;
      prog_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      pend_vld_q    <= pend_vld_d;
      pend_id_q     <= pend_id_d;
      prog_active_q <= prog_active_d;
    end
  end

  // Response steering: the SRAM returns data one cycle after the read grant.
  always_comb begin
    fetch_gnt_o    = fetch_gnt;
    prog_gnt_o     = prog_gnt;
    fetch_rvalid_o = pend_vld_q & ~pend_id_q;
    prog_rvalid_o  = pend_vld_q & pend_id_q;
    fetch_rdata_o  = mem_rdata_i;
    prog_rdata_o   = mem_rdata_i;
    prog_active_o  = prog_active_q;
  end

endmodule

// File: tb/tb_iccm_port_arbiter.sv
// Directed bench for iccm_port_arbiter: inputs change 1ns after the rising
// edge, outputs are sampled 2ns after the rising edge.
module tb_iccm_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          prog_mode_i, prog_req_i, prog_we_i;
  logic [AW-1:0] prog_addr_i;
  logic [DW-1:0] prog_wdata_i, prog_wmask_i;
  logic          prog_gnt_o, prog_rvalid_o;
  logic [DW-1:0] prog_rdata_o;
  logic          fetch_req_i;
  logic [AW-1:0] fetch_addr_i;
  logic          fetch_gnt_o, fetch_rvalid_o;
  logic [DW-1:0] fetch_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_wmask_o;
  logic [DW-1:0] mem_rdata_i;
  logic          prog_active_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  iccm_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .prog_mode_i(prog_mode_i), .prog_req_i(prog_req_i), .prog_we_i(prog_we_i),
    .prog_addr_i(prog_addr_i), .prog_wdata_i(prog_wdata_i), .prog_wmask_i(prog_wmask_i),
    .prog_gnt_o(prog_gnt_o), .prog_rvalid_o(prog_rvalid_o), .prog_rdata_o(prog_rdata_o),
    .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
    .fetch_gnt_o(fetch_gnt_o), .fetch_rvalid_o(fetch_rvalid_o), .fetch_rdata_o(fetch_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_rdata_i(mem_rdata_i),
    .prog_active_o(prog_active_o)
  );

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    prog_mode_i  = 1'b0;
    prog_req_i   = 1'b0;
    prog_we_i    = 1'b0;
    prog_addr_i  = '0;
    prog_wdata_i = '0;
    prog_wmask_i = '0;
    fetch_req_i  = 1'b0;
    fetch_addr_i = '0;
    mem_rdata_i  = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1;
    repeat (2) cyc();
    rst_i = 1'b0;
    cyc();
    #1;
    checks++;
    if ({prog_active_o, prog_rvalid_o, fetch_rvalid_o, mem_req_o, prog_gnt_o, fetch_gnt_o} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=000000",
               {prog_active_o, prog_rvalid_o, fetch_rvalid_o, mem_req_o, prog_gnt_o, fetch_gnt_o});
    end
  endtask

  task automatic test_fetch_read();
    cyc();
    fetch_req_i  = 1'b1;
    fetch_addr_i = 12'h010;
    #1;
    checks++;
    if ({fetch_gnt_o, prog_gnt_o, mem_req_o, mem_we_o} !== 4'b1010 || mem_addr_o !== 12'h010) begin
      failures++;
      $display("FAIL fetch_grant got gnt/pgnt/req/we=%b addr=%h exp=1010 addr=010",
               {fetch_gnt_o, prog_gnt_o, mem_req_o, mem_we_o}, mem_addr_o);
    end
    cyc();
    fetch_req_i = 1'b0;
    mem_rdata_i = 32'hDEADBEEF;
    #1;
    checks++;
    if (fetch_rvalid_o !== 1'b1 || fetch_rdata_o !== 32'hDEADBEEF || prog_rvalid_o !== 1'b0) begin
      failures++;
      $display("FAIL fetch_rvalid got rv=%b data=%h prv=%b exp rv=1 data=deadbeef prv=0",
               fetch_rvalid_o, fetch_rdata_o, prog_rvalid_o);
    end
    cyc();
    mem_rdata_i = '0;
    #1;
    checks++;
    if (fetch_rvalid_o !== 1'b0) begin
      failures++;
      $display("FAIL fetch_rvalid_pulse got=%b exp=0", fetch_rvalid_o);
    end
  endtask

  task automatic test_priority();
    logic exp_f;
    cyc();
    prog_req_i  = 1'b1;
    fetch_req_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_f = ((i % 5) == 4);
      #1;
      checks++;
      if (fetch_gnt_o !== exp_f || prog_gnt_o !== !exp_f) begin
        failures++;
        $display("FAIL priority_cycle%0d got fgnt=%b pgnt=%b exp fgnt=%b pgnt=%b",
                 i, fetch_gnt_o, prog_gnt_o, exp_f, !exp_f);
      end
      cyc();
    end
    prog_req_i  = 1'b0;
    fetch_req_i = 1'b0;
    cyc();
  endtask

  task automatic test_drain();
    fetch_req_i  = 1'b1;
    fetch_addr_i = 12'h020;
    prog_mode_i  = 1'b1;
    #1;
    checks++;
    if (fetch_gnt_o !== 1'b1) begin
      failures++;
      $display("FAIL drain_entry_grant got=%b exp=1", fetch_gnt_o);
    end
    cyc();
    prog_req_i  = 1'b1;
    mem_rdata_i = 32'h12345678;
    #1;
    checks++;
    if ({fetch_gnt_o, prog_gnt_o, mem_req_o, prog_active_o} !== 4'b0000 ||
        fetch_rvalid_o !== 1'b1 || fetch_rdata_o !== 32'h12345678 || prog_rvalid_o !== 1'b0) begin
      failures++;
      $display("FAIL drain_cycle got gnts/req/act=%b frv=%b fdata=%h prv=%b exp 0000 1 12345678 0",
               {fetch_gnt_o, prog_gnt_o, mem_req_o, prog_active_o}, fetch_rvalid_o, fetch_rdata_o,
               prog_rvalid_o);
    end
    cyc();
    prog_req_i  = 1'b0;
    mem_rdata_i = '0;
    #1;
    checks++;
    if (prog_active_o !== 1'b1 || fetch_gnt_o !== 1'b0 || mem_req_o !== 1'b0 || fetch_rvalid_o !== 1'b0) begin
      failures++;
      $display("FAIL prog_entry got act=%b fgnt=%b req=%b frv=%b exp 1 0 0 0",
               prog_active_o, fetch_gnt_o, mem_req_o, fetch_rvalid_o);
    end
    fetch_req_i = 1'b0;
  endtask

  task automatic test_prog_write_read();
    cyc();
    prog_req_i   = 1'b1;
    prog_we_i    = 1'b1;
    prog_addr_i  = 12'h7FF;
    prog_wdata_i = 32'hCAFEF00D;
    prog_wmask_i = 32'hFFFFFFFF;
    #1;
    checks++;
    if ({prog_gnt_o, mem_req_o, mem_we_o} !== 3'b111 || mem_addr_o !== 12'h7FF ||
        mem_wdata_o !== 32'hCAFEF00D || mem_wmask_o !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL prog_write got gnt/req/we=%b addr=%h wd=%h wm=%h exp 111 7ff cafef00d ffffffff",
               {prog_gnt_o, mem_req_o, mem_we_o}, mem_addr_o, mem_wdata_o, mem_wmask_o);
    end
    cyc();
    prog_we_i = 1'b0;
    #1;
    checks++;
    if (prog_gnt_o !== 1'b1 || mem_we_o !== 1'b0 || prog_rvalid_o !== 1'b0 || mem_addr_o !== 12'h7FF) begin
      failures++;
      $display("FAIL prog_read_issue got gnt=%b we=%b prv=%b addr=%h exp 1 0 0 7ff",
               prog_gnt_o, mem_we_o, prog_rvalid_o, mem_addr_o);
    end
    cyc();
    prog_req_i  = 1'b0;
    mem_rdata_i = 32'hCAFEF00D;
    #1;
    checks++;
    if (prog_rvalid_o !== 1'b1 || prog_rdata_o !== 32'hCAFEF00D || fetch_rvalid_o !== 1'b0) begin
      failures++;
      $display("FAIL prog_read_data got prv=%b data=%h frv=%b exp 1 cafef00d 0",
               prog_rvalid_o, prog_rdata_o, fetch_rvalid_o);
    end
    cyc();
    mem_rdata_i = '0;
  endtask

  task automatic test_exit_prog();
    fetch_req_i  = 1'b1;
    fetch_addr_i = 12'h044;
    prog_mode_i  = 1'b0;
    #1;
    checks++;
    if (fetch_gnt_o !== 1'b0 || prog_active_o !== 1'b1) begin
      failures++;
      $display("FAIL exit_last_prog got fgnt=%b act=%b exp 0 1", fetch_gnt_o, prog_active_o);
    end
    cyc();
    #1;
    checks++;
    if (fetch_gnt_o !== 1'b1 || prog_active_o !== 1'b0 || mem_addr_o !== 12'h044) begin
      failures++;
      $display("FAIL exit_first_run got fgnt=%b act=%b addr=%h exp 1 0 044",
               fetch_gnt_o, prog_active_o, mem_addr_o);
    end
    cyc();
    fetch_req_i = 1'b0;
    cyc();
  endtask

  task automatic test_starve_mode();
    prog_req_i  = 1'b1;
    fetch_req_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (prog_gnt_o !== 1'b1) begin
        failures++;
        $display("FAIL starve_prog_cycle%0d got=%b exp=1", i, prog_gnt_o);
      end
      cyc();
    end
    prog_mode_i = 1'b1;
    #1;
    checks++;
    if (fetch_gnt_o !== 1'b1 || prog_gnt_o !== 1'b0) begin
      failures++;
      $display("FAIL starve_mode_fetch_wins got fgnt=%b pgnt=%b exp 1 0", fetch_gnt_o, prog_gnt_o);
    end
    cyc();
    #1;
    checks++;
    if (fetch_gnt_o !== 1'b0 || prog_gnt_o !== 1'b0 || fetch_rvalid_o !== 1'b1 || prog_rvalid_o !== 1'b0) begin
      failures++;
      $display("FAIL starve_drain got fgnt=%b pgnt=%b frv=%b prv=%b exp 0 0 1 0",
               fetch_gnt_o, prog_gnt_o, fetch_rvalid_o, prog_rvalid_o);
    end
    cyc();
    #1;
    checks++;
    if (prog_active_o !== 1'b1 || prog_gnt_o !== 1'b1 || fetch_gnt_o !== 1'b0) begin
      failures++;
      $display("FAIL starve_prog got act=%b pgnt=%b fgnt=%b exp 1 1 0",
               prog_active_o, prog_gnt_o, fetch_gnt_o);
    end
    prog_req_i  = 1'b0;
    fetch_req_i = 1'b0;
    prog_mode_i = 1'b0;
    repeat (2) cyc();
  endtask

  task automatic test_reset_mid_read();
    fetch_req_i  = 1'b1;
    fetch_addr_i = 12'h080;
    #1;
    checks++;
    if (fetch_gnt_o !== 1'b1 || prog_active_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_read_grant got fgnt=%b act=%b exp 1 0", fetch_gnt_o, prog_active_o);
    end
    cyc();
    idle_inputs();
    rst_i = 1'b1;
    #1;
    checks++;
    if ({fetch_rvalid_o, prog_rvalid_o, mem_req_o, prog_active_o, fetch_gnt_o, prog_gnt_o} !== 6'b0) begin
      failures++;
      $display("FAIL mid_read_reset got=%b exp=000000",
               {fetch_rvalid_o, prog_rvalid_o, mem_req_o, prog_active_o, fetch_gnt_o, prog_gnt_o});
    end
    repeat (2) cyc();
    rst_i = 1'b0;
    cyc();
    #1;
    checks++;
    if (fetch_rvalid_o !== 1'b0 || prog_rvalid_o !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_rvalid got frv=%b prv=%b exp 0 0", fetch_rvalid_o, prog_rvalid_o);
    end
    fetch_req_i = 1'b1;
    fetch_addr_i = 12'h0C0;
    #1;
    checks++;
    if (fetch_gnt_o !== 1'b1 || mem_addr_o !== 12'h0C0) begin
      failures++;
      $display("FAIL post_reset_run got fgnt=%b addr=%h exp 1 0c0", fetch_gnt_o, mem_addr_o);
    end
    cyc();
    fetch_req_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_priority();
    test_drain();
    test_prog_write_read();
    test_exit_prog();
    test_starve_mode();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iccm_port_arbiter.md
Name: iccm_port_arbiter

Overview:
- Shares the single ICCM SRAM port between two requesters: the instruction-fetch path (TL-UL SRAM adapter, read-only) and the UART programming path (read/write).
- Sequences ownership of the port with a mode FSM: normal fetch, drain of in-flight reads, then exclusive programming.
- In normal mode, applies fixed priority to the programmer, with a starvation guard for fetch.
- Sits between the adapter/programmer and the ICCM macro, which has a fixed 1-cycle read latency.

Parameters:
AW, 12, SRAM word-address width
DW, 32, SRAM data width
MAX_WAIT, 4, consecutive cycles fetch may be denied in RUN before it is forced to win (range 1..15)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
prog_mode_i  in  1  programming mode request from programming controller (level)
prog_req_i  in  1  programmer access request
prog_we_i  in  1  programmer write enable
prog_addr_i  in  AW  programmer word address
prog_wdata_i  in  DW  programmer write data
prog_wmask_i  in  DW  programmer bit write mask
prog_gnt_o  out  1  programmer request accepted this cycle
prog_rvalid_o  out  1  programmer read data valid
prog_rdata_o  out  DW  programmer read data
fetch_req_i  in  1  fetch read request
fetch_addr_i  in  AW  fetch word address
fetch_gnt_o  out  1  fetch request accepted this cycle
fetch_rvalid_o  out  1  fetch read data valid
fetch_rdata_o  out  DW  fetch read data
mem_req_o  out  1  SRAM request
mem_we_o  out  1  SRAM write enable
mem_addr_o  out  AW  SRAM address
mem_wdata_o  out  DW  SRAM write data
mem_wmask_o  out  DW  SRAM write mask
mem_rdata_i  in  DW  SRAM read data, valid 1 cycle after accepted read
prog_active_o  out  1  high while FSM is in PROG

Behaviour:

Reset and clocking:
- One clock, clk_i. Reset rst_i is asynchronous, active-high.
- On reset: FSM=RUN, wait_cnt=0, pend_vld=0, pend_id=0, prog_rvalid_o=0, fetch_rvalid_o=0, prog_active_o=0.

Grants and SRAM port:
- Grants are combinational from current state and requests. At most one grant per cycle.
- mem_req_o = prog_gnt_o | fetch_gnt_o.
- mem_addr_o, mem_we_o, mem_wdata_o and mem_wmask_o are muxed from the granted requester.
- Fetch grant forces mem_we_o=0. When idle, mem_* are 0.

Read response path:
- On a granted read (mem_we_o=0): register pend_vld=1 and pend_id = requester (0=fetch, 1=prog).
- Next cycle: the selected rvalid pulses for 1 cycle. Both rdata outputs = mem_rdata_i, meaningful only with their rvalid.
- Writes produce no rvalid. The grant is the completion.

FSM states:
- RUN:
  - Prog only -> prog granted.
  - Fetch only -> fetch granted.
  - Both requesting: prog wins unless wait_cnt == MAX_WAIT, in which case fetch wins.
  - wait_cnt increments (saturating at MAX_WAIT) each cycle fetch_req_i=1 and fetch is not granted. It clears when fetch is granted or fetch_req_i=0.
  - prog_mode_i=1 -> DRAIN. Grants still follow RUN rules in the transition cycle.
- DRAIN:
  - No grants.
  - pend_vld=0 at the start of the cycle, or clearing this cycle -> PROG next cycle.
  - prog_mode_i=0 -> RUN (takes precedence).
- PROG:
  - prog_active_o=1. fetch_gnt_o=0 regardless of fetch_req_i. Prog granted whenever it requests.
  - wait_cnt held at 0.
  - prog_mode_i=0 -> RUN next cycle. The first RUN cycle arbitrates normally.

Boundary cases:
- A read granted in the last RUN cycle still returns its rvalid, in DRAIN, to the correct requester.
- No fetch rvalid ever occurs in PROG.
- Reset mid-read: pending rvalid is discarded and no pulse is emitted after reset release.
- Simultaneous prog_mode_i rise and wait_cnt==MAX_WAIT with both requesting: fetch wins that cycle, then DRAIN.
- prog_req_i in DRAIN: not granted; the requester holds it.

Test Plan:
- Reset, then fetch reads addr 0x010 with SRAM returning 0xDEADBEEF -> fetch_gnt_o=1 same cycle, mem_addr_o=0x010, fetch_rvalid_o=1 next cycle with fetch_rdata_o=0xDEADBEEF; prog_rvalid_o stays 0.
- prog_req_i and fetch_req_i held high continuously in RUN, MAX_WAIT=4 -> prog granted cycles 0-3, fetch granted cycle 4, wait_cnt returns to 0, pattern repeats with period 5.
- Fetch read granted, then prog_mode_i raised in the same cycle -> DRAIN for 1 cycle with fetch_rvalid_o=1; PROG next cycle with prog_active_o=1; fetch_req_i ignored there.
- In PROG, write 0xCAFEF00D at 0x7FF with full mask, then read 0x7FF -> mem_we_o=1 on the write with no rvalid; on the read, prog_rvalid_o=1 one cycle later with the SRAM data.
- Drop prog_mode_i while fetch_req_i=1 -> RUN next cycle, fetch_gnt_o=1 that cycle, prog_active_o=0.
- Assert rst_i the cycle after a granted read -> no rvalid emitted, all outputs 0, FSM=RUN after release.
